// File: rtl/store_write_buffer.sv
// Store write buffer: in-order FIFO of committed stores, drained one write at a time
// to the data memory port, with combinational youngest-match forwarding to loads.
module store_write_buffer #(
    parameter int WB_ENTRIES = 4,   // power of two, at least 2
    parameter int DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_vld_i,
    input  logic [DATA_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              wb_full_o,
    output logic              wb_empty_o,
    output logic              mem_req_vld_o,
    output logic [DATA_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_data_o,
    input  logic              mem_req_rdy_i,
    input  logic              mem_ack_i,
    input  logic              ld_vld_i,
    input  logic [DATA_W-1:0] ld_addr_i,
    output logic              ld_hit_o,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              overflow_o
);

    localparam int IDX_W = $clog2(WB_ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ACK
    } state_e;

    state_e                state_q;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [PTR_W-1:0]      count;
    logic [IDX_W-1:0]      head_idx, tail_idx, next_idx, fwd_idx;
    logic [WB_ENTRIES-1:0] valid_q, valid_d;
    logic [DATA_W-1:0]     addr_q [WB_ENTRIES];
    logic [DATA_W-1:0]     data_q [WB_ENTRIES];
    logic                  overflow_q, overflow_d;
    logic                  req_vld_q;
    logic [DATA_W-1:0]     req_addr_q, req_data_q;
    logic                  full, empty, push, pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign next_idx = head_idx + IDX_W'(1);
    assign count    = tail_q - head_q;
    assign full     = (head_q[PTR_W-1] != tail_q[PTR_W-1]) && (head_idx == tail_idx);
    assign empty    = (head_q == tail_q);
    assign push     = in_vld_i && !full;
    assign pop      = (state_q == ST_WAIT_ACK) && mem_ack_i;

    // NOTE: combinational next-state uses blocking assignments with every target
    // defaulted first, so no latch can be inferred on an untaken branch.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        valid_d    = valid_q;
        overflow_d = overflow_q | (in_vld_i && full);
        if (push) begin
            valid_d[tail_idx] = 1'b1;
            tail_d            = tail_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the payload arrays are deliberately left out of reset; an entry is only
    // ever read while its valid bit is set, and the valid bits are reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_idx] <= in_addr_i;
            data_q[tail_idx] <= in_data_i;
        end
    end

    // Drain FSM; the request outputs are registered and loaded on entry to REQ.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            req_vld_q  <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        state_q    <= ST_REQ;
                        req_vld_q  <= 1'b1;
                        req_addr_q <= addr_q[head_idx];
                        req_data_q <= data_q[head_idx];
                    end
                end
                ST_REQ: begin
                    if (mem_req_rdy_i) begin
                        state_q    <= ST_WAIT_ACK;
                        req_vld_q  <= 1'b0;
                        req_addr_q <= '0;
                        req_data_q <= '0;
                    end
                end
                ST_WAIT_ACK: begin
                    if (mem_ack_i) begin
                        if (count > PTR_W'(1)) begin
                            state_q    <= ST_REQ;
                            req_vld_q  <= 1'b1;
                            req_addr_q <= addr_q[next_idx];
                            req_data_q <= data_q[next_idx];
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    req_vld_q  <= 1'b0;
                    req_addr_q <= '0;
                    req_data_q <= '0;
                end
            endcase
        end
    end

    // Walk entries oldest to youngest from head so the last match wins across wrap.
    always_comb begin
        ld_hit_o  = 1'b0;
        ld_data_o = '0;
        fwd_idx   = head_idx;
        for (int k = 0; k < WB_ENTRIES; k++) begin
            fwd_idx = head_idx + IDX_W'(k);
            if (ld_vld_i && valid_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr_i)) begin
                ld_hit_o  = 1'b1;
                ld_data_o = data_q[fwd_idx];
            end
        end
    end

    assign wb_full_o      = full;
    assign wb_empty_o     = empty && (state_q == ST_IDLE);
    assign mem_req_vld_o  = req_vld_q;
    assign mem_req_addr_o = req_addr_q;
    assign mem_req_data_o = req_data_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios with literal expectations, then
// random traffic compared every cycle against a queue-based reference model.
module tb_store_write_buffer;

    localparam int N      = 4;
    localparam int DW     = 32;
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_WAIT = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          in_vld_i;
    logic [DW-1:0] in_addr_i, in_data_i;
    logic          wb_full_o, wb_empty_o;
    logic          mem_req_vld_o;
    logic [DW-1:0] mem_req_addr_o, mem_req_data_o;
    logic          mem_req_rdy_i, mem_ack_i;
    logic          ld_vld_i;
    logic [DW-1:0] ld_addr_i;
    logic          ld_hit_o;
    logic [DW-1:0] ld_data_o;
    logic          overflow_o;

    always #5 clk = ~clk;

    store_write_buffer #(.WB_ENTRIES(N), .DATA_W(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .in_vld_i      (in_vld_i),
        .in_addr_i     (in_addr_i),
        .in_data_i     (in_data_i),
        .wb_full_o     (wb_full_o),
        .wb_empty_o    (wb_empty_o),
        .mem_req_vld_o (mem_req_vld_o),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_req_data_o(mem_req_data_o),
        .mem_req_rdy_i (mem_req_rdy_i),
        .mem_ack_i     (mem_ack_i),
        .ld_vld_i      (ld_vld_i),
        .ld_addr_i     (ld_addr_i),
        .ld_hit_o      (ld_hit_o),
        .ld_data_o     (ld_data_o),
        .overflow_o    (overflow_o)
    );

    typedef struct packed {
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];     // reference buffer contents, oldest first
    ent_t wlog[$];   // writes seen handshaking on the memory port
    int   m_phase = P_IDLE;
    bit   m_ovf   = 1'b0;
    bit   chk_en  = 1'b0;
    int   checks  = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer as a queue, drain progress as idle / request / waiting.
    initial begin
        int held;
        bit pop;
        ent_t e;
        forever begin
            @(posedge clk);
            if (rst_i) begin
                mq.delete();
                m_phase = P_IDLE;
                m_ovf   = 1'b0;
            end else begin
                held = mq.size();
                pop  = (m_phase == P_WAIT) && mem_ack_i;
                if (m_phase == P_IDLE && held > 0)
                    m_phase = P_REQ;
                else if (m_phase == P_REQ && mem_req_rdy_i)
                    m_phase = P_WAIT;
                else if (pop)
                    m_phase = (held > 1) ? P_REQ : P_IDLE;
                if (in_vld_i) begin
                    if (held == N) begin
                        m_ovf = 1'b1;
                    end else begin
                        e.addr = in_addr_i;
                        e.data = in_data_i;
                        mq.push_back(e);
                    end
                end
                if (pop) void'(mq.pop_front());
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic          exp_hit;
        logic [DW-1:0] exp_ld, exp_addr, exp_data;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_hit = 1'b0;
                exp_ld  = '0;
                if (ld_vld_i) begin
                    for (int i = mq.size() - 1; i >= 0; i--) begin
                        if (!exp_hit && mq[i].addr == ld_addr_i) begin
                            exp_hit = 1'b1;
                            exp_ld  = mq[i].data;
                        end
                    end
                end
                exp_addr = '0;
                exp_data = '0;
                if (m_phase == P_REQ && mq.size() > 0) begin
                    exp_addr = mq[0].addr;
                    exp_data = mq[0].data;
                end
                check("m.full",     DW'(wb_full_o),     DW'(mq.size() == N));
                check("m.empty",    DW'(wb_empty_o),    DW'(mq.size() == 0 && m_phase == P_IDLE));
                check("m.req_vld",  DW'(mem_req_vld_o), DW'(m_phase == P_REQ));
                check("m.req_addr", mem_req_addr_o,     exp_addr);
                check("m.req_data", mem_req_data_o,     exp_data);
                check("m.ld_hit",   DW'(ld_hit_o),      DW'(exp_hit));
                check("m.ld_data",  ld_data_o,          exp_ld);
                check("m.overflow", DW'(overflow_o),    DW'(m_ovf));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i && mem_req_vld_o && mem_req_rdy_i)
                wlog.push_back({mem_req_addr_o, mem_req_data_o});
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) nxt();
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] d);
        in_vld_i  = 1'b1;
        in_addr_i = a;
        in_data_i = d;
    endtask

    initial begin
        int n20;
        rst_i = 1'b1; in_vld_i = 1'b0; in_addr_i = '0; in_data_i = '0;
        ld_vld_i = 1'b0; ld_addr_i = '0; mem_req_rdy_i = 1'b0; mem_ack_i = 1'b0;
        nxt(); nxt();
        rst_i  = 1'b0;
        chk_en = 1'b1;
        mid();
        check("rst.empty",    DW'(wb_empty_o),    32'd1);
        check("rst.full",     DW'(wb_full_o),     32'd0);
        check("rst.req_vld",  DW'(mem_req_vld_o), 32'd0);
        check("rst.req_addr", mem_req_addr_o,     32'd0);
        check("rst.overflow", DW'(overflow_o),    32'd0);

        // Basic drain
        nxt();
        wlog.delete();
        mem_req_rdy_i = 1'b1;
        push(32'h100, 32'hDEADBEEF);
        nxt();
        in_vld_i = 1'b0;
        mid(); check("drain.vld_early", DW'(mem_req_vld_o), 32'd0);
        nxt();
        mid(); check("drain.vld", DW'(mem_req_vld_o), 32'd1);
        check("drain.addr", mem_req_addr_o, 32'h100);
        check("drain.data", mem_req_data_o, 32'hDEADBEEF);
        nxt();
        mid(); check("drain.vld_once", DW'(mem_req_vld_o), 32'd0);
        nxt(); nxt();
        mem_ack_i = 1'b1;
        mid(); check("drain.empty_pre", DW'(wb_empty_o), 32'd0);
        nxt();
        mem_ack_i = 1'b0;
        mid(); check("drain.empty_post", DW'(wb_empty_o), 32'd1);
        check("drain.nwrites", DW'(wlog.size()), 32'd1);

        // Back-pressure and ordering
        nxt();
        mem_req_rdy_i = 1'b0;
        wlog.delete();
        push(32'h10, 32'd1); nxt();
        push(32'h14, 32'd2); nxt();
        push(32'h18, 32'd3);
        mid(); check("bp.vld", DW'(mem_req_vld_o), 32'd1); check("bp.addr3", mem_req_addr_o, 32'h10);
        nxt();
        push(32'h1C, 32'd4);
        mid(); check("bp.full3", DW'(wb_full_o), 32'd0); check("bp.addr4", mem_req_addr_o, 32'h10);
        nxt();
        in_vld_i = 1'b0;
        mid(); check("bp.full4", DW'(wb_full_o), 32'd1); check("bp.data5", mem_req_data_o, 32'd1);
        nxt();
        mem_req_rdy_i = 1'b1;
        mid(); check("bp.addr6", mem_req_addr_o, 32'h10);
        nxt();
        mem_ack_i = 1'b1;
        mid(); check("bp.full_wait", DW'(wb_full_o), 32'd1);
        nxt();
        mid(); check("bp.full_drop", DW'(wb_full_o), 32'd0);
        run(12);
        mem_ack_i = 1'b0; mem_req_rdy_i = 1'b0;
        check("bp.nwrites", DW'(wlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) begin
                check("bp.order_data", wlog[i].data, DW'(i + 1));
                check("bp.order_addr", wlog[i].addr, DW'(32'h10 + 4 * i));
            end
        end

        // Overflow
        wlog.delete();
        push(32'h30, 32'h31); nxt();
        push(32'h34, 32'h35); nxt();
        push(32'h38, 32'h39); nxt();
        push(32'h3C, 32'h3D); nxt();
        push(32'h20, 32'd5);
        mid(); check("ovf.full", DW'(wb_full_o), 32'd1); check("ovf.pre", DW'(overflow_o), 32'd0);
        nxt();
        in_vld_i = 1'b0;
        mid(); check("ovf.set", DW'(overflow_o), 32'd1);
        run(3);
        mem_req_rdy_i = 1'b1; mem_ack_i = 1'b1;
        run(14);
        mem_req_rdy_i = 1'b0; mem_ack_i = 1'b0;
        n20 = 0;
        foreach (wlog[i]) if (wlog[i].addr == 32'h20) n20++;
        check("ovf.nwrites", DW'(wlog.size()), 32'd4);
        check("ovf.no_0x20", DW'(n20), 32'd0);
        mid(); check("ovf.sticky", DW'(overflow_o), 32'd1);
        nxt();

        // Forwarding with wrapped pointers
        mem_req_rdy_i = 1'b1; mem_ack_i = 1'b1;
        push(32'h50, 32'h51); nxt();
        push(32'h54, 32'h55); nxt();
        in_vld_i = 1'b0;
        run(8);
        mem_req_rdy_i = 1'b0; mem_ack_i = 1'b0;
        push(32'h40, 32'hA); nxt();
        push(32'h44, 32'hB); nxt();
        push(32'h40, 32'hC); nxt();
        in_vld_i = 1'b0; ld_vld_i = 1'b1; ld_addr_i = 32'h40;
        mid(); check("fwd.hit40", DW'(ld_hit_o), 32'd1); check("fwd.data40", ld_data_o, 32'hC);
        nxt();
        ld_addr_i = 32'h48;
        mid(); check("fwd.hit48", DW'(ld_hit_o), 32'd0); check("fwd.data48", ld_data_o, 32'd0);
        nxt();
        ld_addr_i = 32'h44;
        mid(); check("fwd.data44", ld_data_o, 32'hB);
        nxt();
        ld_vld_i = 1'b0; ld_addr_i = 32'h40;
        mid(); check("fwd.novld", DW'(ld_hit_o), 32'd0);
        nxt();
        mem_req_rdy_i = 1'b1; mem_ack_i = 1'b1;
        run(10);
        mem_req_rdy_i = 1'b1; mem_ack_i = 1'b0;

        // Simultaneous push, pop and forward
        push(32'h80, 32'd7); nxt();
        in_vld_i = 1'b0; nxt();
        mid(); check("spf.req_addr", mem_req_addr_o, 32'h80);
        nxt();
        mem_req_rdy_i = 1'b0;
        mid(); check("spf.wait", DW'(mem_req_vld_o), 32'd0);
        nxt();
        mem_ack_i = 1'b1; push(32'h84, 32'd8); ld_vld_i = 1'b1; ld_addr_i = 32'h80;
        mid(); check("spf.hit_same", DW'(ld_hit_o), 32'd1); check("spf.data_same", ld_data_o, 32'd7);
        nxt();
        mem_ack_i = 1'b0; in_vld_i = 1'b0;
        mid(); check("spf.hit_next", DW'(ld_hit_o), 32'd0); check("spf.idle_vld", DW'(mem_req_vld_o), 32'd0);
        check("spf.not_empty", DW'(wb_empty_o), 32'd0);
        nxt();
        ld_addr_i = 32'h84;
        mid(); check("spf.req84", mem_req_addr_o, 32'h84); check("spf.data84", mem_req_data_o, 32'd8);
        nxt();
        ld_vld_i = 1'b0; mem_req_rdy_i = 1'b1; mem_ack_i = 1'b1;
        run(6);
        mem_req_rdy_i = 1'b0; mem_ack_i = 1'b0;

        // Reset mid-operation
        push(32'h90, 32'd1); nxt();
        push(32'h94, 32'd2); nxt();
        push(32'h98, 32'd3); nxt();
        in_vld_i = 1'b0;
        mid(); check("rmid.vld", DW'(mem_req_vld_o), 32'd1); check("rmid.ovf_pre", DW'(overflow_o), 32'd1);
        nxt();
        rst_i = 1'b1;
        nxt();
        rst_i = 1'b0; ld_vld_i = 1'b1; ld_addr_i = 32'h94;
        mid();
        check("rmid.vld0",  DW'(mem_req_vld_o), 32'd0);
        check("rmid.empty", DW'(wb_empty_o),    32'd1);
        check("rmid.full",  DW'(wb_full_o),     32'd0);
        check("rmid.ovf",   DW'(overflow_o),    32'd0);
        check("rmid.hit",   DW'(ld_hit_o),      32'd0);
        nxt();
        ld_addr_i = 32'h90;
        mid(); check("rmid.hit90", DW'(ld_hit_o), 32'd0);
        nxt();

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst_i         = ($urandom_range(0, 299) == 0);
            in_vld_i      = ($urandom_range(0, 9) < 4);
            in_addr_i     = DW'($urandom_range(0, 7) * 4);
            in_data_i     = $urandom;
            ld_vld_i      = ($urandom_range(0, 1) == 1);
            ld_addr_i     = DW'($urandom_range(0, 8) * 4);
            mem_req_rdy_i = ($urandom_range(0, 2) != 0);
            mem_ack_i     = ($urandom_range(0, 3) == 0);
            nxt();
        end
        rst_i = 1'b0; in_vld_i = 1'b0; ld_vld_i = 1'b0; mem_req_rdy_i = 1'b0; mem_ack_i = 1'b0;
        nxt(); nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Receives committed stores issued by the store data queue and drains them to the data memory port, one at a time.
- Stores are held in a small in-order FIFO. Writes use a valid/ready request followed by a write acknowledge.
- Also forwards data combinationally to younger loads that hit a buffered store, because those stores are no longer visible in the SDQ.

Parameters:
- WB_ENTRIES, 4, buffer depth; must be a power of two and at least 2.
- DATA_W, 32, width of store data and address.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- in_vld_i  in  1  issued store valid (SDQ issue_vld).
- in_addr_i  in  DATA_W  store address (issue_entry.addr).
- in_data_i  in  DATA_W  store data (issue_entry.store_data).
- wb_full_o  out  1  buffer full; the SDQ must not issue while this is high.
- wb_empty_o  out  1  no stores buffered or in flight; used for fences.
- mem_req_vld_o  out  1  write request valid.
- mem_req_addr_o  out  DATA_W  write address.
- mem_req_data_o  out  DATA_W  write data.
- mem_req_rdy_i  in  1  memory accepts the request.
- mem_ack_i  in  1  write completed.
- ld_vld_i  in  1  load forwarding lookup valid.
- ld_addr_i  in  DATA_W  load address.
- ld_hit_o  out  1  load matched a buffered store.
- ld_data_o  out  DATA_W  forwarded data.
- overflow_o  out  1  sticky error: a push arrived while full.

Behaviour:
- Reset (synchronous, active-high): head, tail and count all 0; FSM to IDLE; every entry valid bit cleared; overflow_o = 0.
- Outputs after reset: wb_full_o = 0, wb_empty_o = 1, mem_req_vld_o = 0, mem_req_addr_o = 0, mem_req_data_o = 0, ld_hit_o = 0, ld_data_o = 0.
- A reset mid-transfer drops every entry, including the one in flight. mem_req_vld_o is low in the first cycle after reset.
- Pointers are $clog2(WB_ENTRIES)+1 bits wide; the MSB is the wrap bit.
  - full = MSBs differ and index bits equal.
  - empty = pointers equal.
  - wb_full_o is driven from the registers only; it does not see a pop in the same cycle.
- Push (in_vld_i && !full): at the clock edge, write {addr, data, valid = 1} at tail, then tail+1.
- Push while full: the entry is dropped, overflow_o sets and stays set until reset, and pointers are unchanged.
- Push and pop in the same cycle are both performed; count is unchanged.
- FSM states are IDLE, REQ and WAIT_ACK.
  - IDLE: if not empty, go to REQ at the next edge.
  - REQ: mem_req_vld_o = 1. Address and data come from the head entry and stay stable until handshake. On mem_req_vld_o && mem_req_rdy_i, go to WAIT_ACK.
  - WAIT_ACK: mem_req_vld_o = 0. On mem_ack_i, pop the head (clear its valid bit, head+1). Then go to REQ if more than 1 entry was held, otherwise go to IDLE.
  - mem_ack_i outside WAIT_ACK is ignored. There is only one outstanding write at a time.
- mem_req_addr_o and mem_req_data_o are 0 whenever the FSM is not in REQ.
- Latency: a push at edge E0 gives mem_req_vld_o high in the cycle after E1. This is 2 cycles from push to request.
- wb_empty_o = empty && state == IDLE.
- Forwarding (combinational): search every valid entry, including the head while it is in flight.
  - If any entry's address equals ld_addr_i exactly (full-width compare), ld_hit_o = 1 and ld_data_o = data of the youngest match, i.e. the one nearest tail, respecting wrap.
  - If nothing matches, or ld_vld_i = 0, both outputs are 0.
  - An entry pushed in the current cycle is not visible until the next cycle.
  - An entry popped at an edge is no longer visible after that edge.
- Word-granular only; there are no byte masks. Committed stores are never flushed, so there is no flush port.

Test Plan:
- Basic drain:
  - Stimulus: after reset, push {addr 0x100, data 0xDEADBEEF}; mem_req_rdy_i = 1; mem_ack_i pulsed 3 cycles after the handshake.
  - Required: mem_req_vld_o rises 2 cycles after the push with addr 0x100 and data 0xDEADBEEF. It is held for exactly one handshake cycle. wb_empty_o returns to 1 the cycle after the ack.
- Back-pressure and ordering:
  - Stimulus: push 0x10/1, 0x14/2, 0x18/3, 0x1C/4 on consecutive cycles; hold mem_req_rdy_i = 0 for 5 cycles.
  - Required: wb_full_o = 1 after the 4th push. Address and data stay at 0x10/1 while ready is low. Writes complete in order 1, 2, 3, 4. wb_full_o drops on the first ack.
- Overflow:
  - Stimulus: fill all 4 entries, then push 0x20/5.
  - Required: overflow_o = 1 and stays set. 0x20 never appears on the memory port. Only 4 writes are issued.
- Forwarding priority with wrap:
  - Stimulus: drain 2 entries so the pointers wrap; push 0x40/0xA, then 0x44/0xB, then 0x40/0xC; look up 0x40.
  - Required: ld_hit_o = 1 and ld_data_o = 0xC. A lookup of 0x48 gives ld_hit_o = 0 and ld_data_o = 0.
- Simultaneous push, pop and forward:
  - Stimulus: with 1 entry {0x80, 7} in WAIT_ACK, assert mem_ack_i while pushing {0x84, 8}; look up 0x80 in the same cycle and in the next cycle.
  - Required: same cycle: hit, data 7. Next cycle: no hit. Count stays 1 and the FSM goes to IDLE, then REQ with 0x84.
- Reset mid-operation:
  - Stimulus: assert rst_i while in REQ with 3 entries held.
  - Required: next cycle mem_req_vld_o = 0, wb_empty_o = 1, wb_full_o = 0, overflow_o = 0. No stale forwarding hits on the old addresses.
